// File: rtl/pacman_pkg.sv
// Shared encodings for the Pacman move controller: FSM states, direction,
// position/score select, timer select and plot colour codes.
package pacman_pkg;

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] INIT  = 4'd1;
  localparam logic [3:0] DRAW  = 4'd2;
  localparam logic [3:0] WAIT  = 4'd3;
  localparam logic [3:0] ERASE = 4'd4;
  localparam logic [3:0] MOVE  = 4'd5;
  localparam logic [3:0] CHECK = 4'd6;
  localparam logic [3:0] SCORE = 4'd7;
  localparam logic [3:0] LOSE  = 4'd8;
  localparam logic [3:0] WIN   = 4'd9;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  localparam logic [1:0] SEL_INIT = 2'd0;
  localparam logic [1:0] SEL_INC  = 2'd1;
  localparam logic [1:0] SEL_DEC  = 2'd2;

  localparam logic [1:0] TMR_CLEAR = 2'd0;
  localparam logic [1:0] TMR_COUNT = 2'd1;

  localparam logic [1:0] COL_BG  = 2'd0;
  localparam logic [1:0] COL_PAC = 2'd1;

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// Controller <-> datapath bundle: datapath status in, enable/select strobes out.
// master = controller side, slave = datapath side.
interface pacman_move_ctrl_if;

  logic       timer_done;
  logic       actuallyBadGhost;
  logic [3:0] score;
  logic [7:0] x_plot;
  logic [6:0] y_plot;

  logic       en_x_position;
  logic       en_y_position;
  logic [1:0] s_x_position;
  logic [1:0] s_y_position;
  logic       en_direction;
  logic [1:0] s_direction;
  logic       en_timer;
  logic [1:0] s_timer;
  logic       en_score;
  logic       s_score;
  logic [1:0] s_plot_color;
  logic       plot;

  modport master (
    input  timer_done, actuallyBadGhost, score, x_plot, y_plot,
    output en_x_position, en_y_position, s_x_position, s_y_position,
           en_direction, s_direction, en_timer, s_timer,
           en_score, s_score, s_plot_color, plot
  );

  modport slave (
    output timer_done, actuallyBadGhost, score, x_plot, y_plot,
    input  en_x_position, en_y_position, s_x_position, s_y_position,
           en_direction, s_direction, en_timer, s_timer,
           en_score, s_score, s_plot_color, plot
  );

endinterface

// File: rtl/pacman_move_ctrl.sv
// Pacman game-loop FSM driving the datapath strobes. Define PACMAN_CTRL_PAUSE_EN
// to add a pause input that freezes the WAIT state and its frame timer.
module pacman_move_ctrl
  import pacman_pkg::*;
#(
  parameter logic [7:0] X_MIN     = 8'd5,
  parameter logic [7:0] X_MAX     = 8'd155,
  parameter logic [6:0] Y_MIN     = 7'd5,
  parameter logic [6:0] Y_MAX     = 7'd115,
  parameter logic [7:0] X_GOAL    = 8'd155,
  parameter logic [3:0] WIN_SCORE = 4'd9
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  startGame,
  input  logic [1:0]            direction,
`ifdef PACMAN_CTRL_PAUSE_EN
  input  logic                  pause,
`endif
  pacman_move_ctrl_if.master    dp,
  output logic                  game_over,
  output logic                  game_won
);

  logic [3:0] state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       paused;

`ifdef PACMAN_CTRL_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE:  if (startGame) state_d = INIT;
      INIT:  state_d = DRAW;
      DRAW:  state_d = WAIT;
      WAIT:  if (!paused && dp.timer_done) state_d = ERASE;
      ERASE: begin
        dir_d   = direction;
        state_d = MOVE;
      end
      MOVE:  state_d = CHECK;
      CHECK: begin
        if (dp.actuallyBadGhost)       state_d = LOSE;
        else if (dp.score >= WIN_SCORE) state_d = WIN;
        else if (dp.x_plot == X_GOAL)   state_d = SCORE;
        else                            state_d = DRAW;
      end
      SCORE: state_d = DRAW;
      LOSE:  if (startGame) state_d = INIT;
      WIN:   if (startGame) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    dp.en_x_position = 1'b0;
    dp.en_y_position = 1'b0;
    dp.s_x_position  = SEL_INIT;
    dp.s_y_position  = SEL_INIT;
    dp.en_direction  = 1'b0;
    dp.s_direction   = DIR_RIGHT;
    dp.en_timer      = 1'b0;
    dp.s_timer       = TMR_CLEAR;
    dp.en_score      = 1'b0;
    dp.s_score       = 1'b0;
    dp.s_plot_color  = COL_BG;
    dp.plot          = 1'b0;
    game_over        = 1'b0;
    game_won         = 1'b0;
    case (state_q)
      INIT: begin
        dp.en_x_position = 1'b1;
        dp.en_y_position = 1'b1;
        dp.en_score      = 1'b1;
        dp.en_timer      = 1'b1;
      end
      DRAW: begin
        dp.plot         = 1'b1;
        dp.s_plot_color = COL_PAC;
      end
      WAIT: begin
        dp.en_timer = !paused;
        dp.s_timer  = TMR_COUNT;
      end
      ERASE: begin
        dp.plot         = 1'b1;
        dp.en_timer     = 1'b1;
        dp.en_direction = 1'b1;
        dp.s_direction  = direction;
      end
      // Moves use the direction latched in ERASE; a move at a wall asserts nothing.
      MOVE: begin
        case (dir_q)
          DIR_RIGHT: if (dp.x_plot < X_MAX) begin
            dp.en_x_position = 1'b1;
            dp.s_x_position  = SEL_INC;
          end
          DIR_LEFT: if (dp.x_plot > X_MIN) begin
            dp.en_x_position = 1'b1;
            dp.s_x_position  = SEL_DEC;
          end
          DIR_UP: if (dp.y_plot > Y_MIN) begin
            dp.en_y_position = 1'b1;
            dp.s_y_position  = SEL_DEC;
          end
          default: if (dp.y_plot < Y_MAX) begin
            dp.en_y_position = 1'b1;
            dp.s_y_position  = SEL_INC;
          end
        endcase
      end
      SCORE: begin
        dp.en_score      = 1'b1;
        dp.s_score       = 1'b1;
        dp.en_x_position = 1'b1;
        dp.en_y_position = 1'b1;
      end
      LOSE: game_over = 1'b1;
      WIN:  game_won  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Scoreboard bench for pacman_move_ctrl: expected per-cycle strobes are queued
// with each stimulus step and compared at the following negedge.
module tb_pacman_move_ctrl;
  import pacman_pkg::*;

  typedef struct packed {
    logic       en_x;
    logic       en_y;
    logic [1:0] s_x;
    logic [1:0] s_y;
    logic       en_dir;
    logic [1:0] s_dir;
    logic       en_timer;
    logic [1:0] s_timer;
    logic       en_score;
    logic       s_score;
    logic [1:0] col;
    logic       plot;
    logic       over;
    logic       won;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
  } sb_t;

  logic       clk;
  logic       resetn;
  logic       startGame;
  logic [1:0] direction;
`ifdef PACMAN_CTRL_PAUSE_EN
  logic       pause;
`endif
  logic       game_over;
  logic       game_won;
  out_t       obs;
  sb_t        sb_q[$];
  int         n_compared;
  int         n_mismatched;

  pacman_move_ctrl_if dp_if ();

  pacman_move_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .startGame (startGame),
    .direction (direction),
`ifdef PACMAN_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .dp        (dp_if.master),
    .game_over (game_over),
    .game_won  (game_won)
  );

  assign obs = {dp_if.en_x_position, dp_if.en_y_position, dp_if.s_x_position,
                dp_if.s_y_position, dp_if.en_direction, dp_if.s_direction,
                dp_if.en_timer, dp_if.s_timer, dp_if.en_score, dp_if.s_score,
                dp_if.s_plot_color, dp_if.plot, game_over, game_won};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want summary before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %05h want %05h", tag, got, want);
    end
  endtask

  // Queue the expectation for the current state, compare at negedge, advance one cycle.
  task automatic cycle(input string tag, input out_t e);
    sb_t s;
    sb_q.push_back('{tag, e});
    @(negedge clk);
    s = sb_q.pop_front();
    check(s.tag, 32'(obs), 32'(s.exp));
    @(posedge clk);
    #1;
  endtask

  function automatic out_t e_none();
    return '0;
  endfunction

  function automatic out_t e_init();
    out_t e = '0;
    e.en_x = 1'b1; e.en_y = 1'b1; e.en_score = 1'b1; e.en_timer = 1'b1;
    return e;
  endfunction

  function automatic out_t e_draw();
    out_t e = '0;
    e.plot = 1'b1; e.col = 2'd1;
    return e;
  endfunction

  function automatic out_t e_wait();
    out_t e = '0;
    e.en_timer = 1'b1; e.s_timer = 2'd1;
    return e;
  endfunction

  function automatic out_t e_erase(input logic [1:0] d);
    out_t e = '0;
    e.plot = 1'b1; e.en_timer = 1'b1; e.en_dir = 1'b1; e.s_dir = d;
    return e;
  endfunction

  function automatic out_t e_move_x(input logic [1:0] sel);
    out_t e = '0;
    e.en_x = 1'b1; e.s_x = sel;
    return e;
  endfunction

  function automatic out_t e_move_y(input logic [1:0] sel);
    out_t e = '0;
    e.en_y = 1'b1; e.s_y = sel;
    return e;
  endfunction

  function automatic out_t e_score();
    out_t e = '0;
    e.en_score = 1'b1; e.s_score = 1'b1; e.en_x = 1'b1; e.en_y = 1'b1;
    return e;
  endfunction

  function automatic out_t e_lose();
    out_t e = '0;
    e.over = 1'b1;
    return e;
  endfunction

  function automatic out_t e_win();
    out_t e = '0;
    e.won = 1'b1;
    return e;
  endfunction

  // From WAIT: fire the timer, ERASE with direction d, then MOVE with a
  // scrambled live direction so only the latched one may steer.
  task automatic step(input string tag, input logic [1:0] d,
                      input logic [7:0] x, input logic [6:0] y, input out_t m);
    dp_if.timer_done = 1'b1;
    cycle({tag, "_wait"}, e_wait());
    dp_if.timer_done = 1'b0;
    direction   = d;
    dp_if.x_plot = x;
    dp_if.y_plot = y;
    cycle({tag, "_erase"}, e_erase(d));
    direction = d ^ 2'b01;
    cycle({tag, "_move"}, m);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn       = 1'b0;
    startGame    = 1'b0;
    direction    = 2'd0;
`ifdef PACMAN_CTRL_PAUSE_EN
    pause        = 1'b0;
`endif
    dp_if.timer_done       = 1'b0;
    dp_if.actuallyBadGhost = 1'b0;
    dp_if.score            = 4'd0;
    dp_if.x_plot           = 8'd20;
    dp_if.y_plot           = 7'd50;
    @(posedge clk);
    #1;

    cycle("reset", e_none());
    resetn = 1'b1;
    cycle("idle_hold", e_none());
    startGame = 1'b1;
    cycle("idle_start", e_none());
    startGame = 1'b0;
    cycle("init", e_init());
    cycle("draw", e_draw());
    cycle("wait_idle", e_wait());

    step("right", DIR_RIGHT, 8'd20, 7'd50, e_move_x(SEL_INC));
    cycle("right_check", e_none());
    cycle("right_draw", e_draw());

    step("left_edge", DIR_LEFT, 8'd5, 7'd50, e_none());
    cycle("left_edge_check", e_none());
    cycle("left_edge_draw", e_draw());

    step("left", DIR_LEFT, 8'd20, 7'd50, e_move_x(SEL_DEC));
    cycle("left_check", e_none());
    cycle("left_draw", e_draw());

    step("up", DIR_UP, 8'd20, 7'd6, e_move_y(SEL_DEC));
    cycle("up_check", e_none());
    cycle("up_draw", e_draw());

    step("up_edge", DIR_UP, 8'd20, 7'd5, e_none());
    cycle("up_edge_check", e_none());
    cycle("up_edge_draw", e_draw());

    step("down", DIR_DOWN, 8'd20, 7'd114, e_move_y(SEL_INC));
    cycle("down_check", e_none());
    cycle("down_draw", e_draw());

    // Goal reached with score 3: one SCORE cycle, then straight back to DRAW.
    dp_if.score = 4'd3;
    step("right_edge", DIR_RIGHT, 8'd155, 7'd50, e_none());
    cycle("goal_check", e_none());
    cycle("score", e_score());
    dp_if.x_plot = 8'd5;
    cycle("score_draw", e_draw());
    cycle("score_wait", e_wait());

    // Ghost and goal together: collision wins.
    step("goal2", DIR_RIGHT, 8'd154, 7'd50, e_move_x(SEL_INC));
    dp_if.x_plot           = 8'd155;
    dp_if.actuallyBadGhost = 1'b1;
    cycle("ghost_check", e_none());
    dp_if.actuallyBadGhost = 1'b0;
    cycle("lose", e_lose());
    cycle("lose_hold", e_lose());
    startGame = 1'b1;
    cycle("lose_start", e_lose());
    cycle("init2", e_init());
    cycle("draw2_start_held", e_draw());
    startGame = 1'b0;
    cycle("wait2", e_wait());

    dp_if.score = 4'd9;
    step("down_edge", DIR_DOWN, 8'd20, 7'd115, e_none());
    cycle("win_check", e_none());
    cycle("win", e_win());
    cycle("win_hold", e_win());
    startGame = 1'b1;
    cycle("win_start", e_win());
    startGame   = 1'b0;
    dp_if.score = 4'd0;
    cycle("init3", e_init());
    cycle("draw3", e_draw());

`ifdef PACMAN_CTRL_PAUSE_EN
    begin
      out_t p;
      p = e_wait();
      p.en_timer = 1'b0;
      pause = 1'b1;
      dp_if.timer_done = 1'b1;
      cycle("pause_wait", p);
      cycle("pause_hold", p);
      pause = 1'b0;
      dp_if.timer_done = 1'b0;
    end
`endif

    cycle("wait3", e_wait());
    resetn = 1'b0;
    cycle("reset_mid_wait", e_none());
    resetn    = 1'b1;
    startGame = 1'b1;
    cycle("idle_after_reset", e_none());
    startGame = 1'b0;
    cycle("init4", e_init());
    cycle("draw4", e_draw());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
